// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   HACK_WORD : default datapath width of the Hack machine
//   state_t   : controller state encoding (IDLE=0, RUN=1, DONE=2)
package serial_adder_pkg;

    localparam int HACK_WORD = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell built from two half adders and an OR.
// The first half adder sums the operand bits, the second folds in the
// incoming carry; the two partial carries can never both be 1, so an OR
// combines them.
//   a, b  : operand bits
//   c     : carry in
//   sum   : a ^ b ^ c
//   carry : carry out
module serial_adder_full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    logic sum1;
    logic carry1;
    logic carry2;

    serial_adder_half_adder u_ha_ab (
        .a     (a),
        .b     (b),
        .sum   (sum1),
        .carry (carry1)
    );

    serial_adder_half_adder u_ha_c (
        .a     (sum1),
        .b     (c),
        .sum   (sum),
        .carry (carry2)
    );

    assign carry = carry1 | carry2;

endmodule

// One-bit half adder: sum = a ^ b, carry = a & b.
module serial_adder_half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit unsigned adder, LSB first, one full-adder cell.
// A request is accepted when idle or in the done cycle; the operands are
// then consumed one bit per clock and the result is published WIDTH edges
// after the accepting edge.
//
// Handshake: start is sampled at a rising edge only while the adder is
// IDLE or DONE; a high start there accepts a and b on that same edge.
// start during RUN is dropped. done is high for exactly one cycle per
// completed operation; sum/carry hold the last completed result until the
// next completion.
//
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request
//   a, b  : operands, captured on the accepting edge
//   busy  : high while bits are being processed (state RUN)
//   done  : one-cycle completion pulse (state DONE)
//   sum   : (a+b) mod 2^WIDTH of the last completed operation
//   carry : carry out of bit WIDTH-1 of the last completed operation
//   state : controller state, for observation
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = HACK_WORD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output state_t           state
);

    localparam int CW = $clog2(WIDTH);
    // Terminal count fits exactly in CW bits; no extra bit is carried.
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             c_q;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] r_next;
    logic             accept;

    serial_adder_full_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (c_q),
        .sum   (s_bit),
        .carry (c_next)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit 0 of the
    // result sits at position 0.
    assign r_next = {s_bit, r_sr[WIDTH-1:1]};
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt == LAST) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            r_sr    <= '0;
            c_q     <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            carry   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_sr <= a;
                b_sr <= b;
                c_q  <= 1'b0;
                cnt  <= '0;
            end else if (state_q == RUN) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                r_sr <= r_next;
                c_q  <= c_next;
                cnt  <= cnt + 1'b1;
                if (cnt == LAST) begin
                    sum   <= r_next;
                    carry <= c_next;
                end
            end
        end
    end

    // Both flags decode the state register only, so neither has a
    // combinational path from any input.
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign state = state_q;

endmodule
